player_motion_ctrl: RTL and testbench



---
 rtl/player_pkg.sv | 23 ++
 rtl/player_motion_ctrl_if.sv | 29 ++
 rtl/player_motion_ctrl_run_anim_counter.sv | 52 +++++
 rtl/player_motion_ctrl.sv | 150 +++++++++++++++
 tb/tb_player_motion_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/player_pkg.sv
// Shared definitions for the runner-demo player, sprite renderer and collision detector.
package player_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_JUMP   = 2'd1,
    ST_CROUCH = 2'd2,
    ST_DEAD   = 2'd3
  } state_t;

  localparam int ID_WIDTH = 4;

  // Sprite ROM ids; run frames occupy 0..RUN_FRAMES-1 below these.
  localparam int JUMP_ID_DEF   = 3;
  localparam int CROUCH_ID_DEF = 4;
  localparam int DEAD_ID_DEF   = 5;

  // Playfield geometry (display is rotated: x is height above the floor).
  localparam int GROUND_X_DEF = 95;
  localparam int PLAYER_Y_DEF = 119;
  localparam int MAX_X_DEF    = 239;

endpackage

// File: rtl/player_motion_ctrl_if.sv
// Game-tick inputs and sprite outputs of the player motion controller.
interface player_motion_ctrl_if #(
  parameter int X_WIDTH = 8,
  parameter int Y_WIDTH = 9
);
  import player_pkg::*;

  logic                update;
  logic [3:0]          keys;
  logic                collision;
  logic                restart;
  logic [X_WIDTH-1:0]  xSprite;
  logic [Y_WIDTH-1:0]  ySprite;
  logic [ID_WIDTH-1:0] spriteId;
  logic                airborne;
  logic                dead;

  // Game logic side: drives tick inputs, consumes sprite state.
  modport master (
    output update, keys, collision, restart,
    input  xSprite, ySprite, spriteId, airborne, dead
  );

  // Motion controller side.
  modport slave (
    input  update, keys, collision, restart,
    output xSprite, ySprite, spriteId, airborne, dead
  );
endinterface

// File: rtl/player_motion_ctrl_run_anim_counter.sv
// Run-cycle animation: ANIM_DIV ticks per frame, frames wrap 0..RUN_FRAMES-1.
module run_anim_counter
  import player_pkg::*;
#(
  parameter int RUN_FRAMES = 3,
  parameter int ANIM_DIV   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  output logic [ID_WIDTH-1:0] frame
);

  localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DW-1:0]       DIV_LAST   = DW'(ANIM_DIV - 1);
  localparam logic [ID_WIDTH-1:0] FRAME_LAST = ID_WIDTH'(RUN_FRAMES - 1);

  logic [DW-1:0]       div_q, div_n;
  logic [ID_WIDTH-1:0] frame_q, frame_n;

  // Next divider/frame; clear wins so a fresh run always starts at frame 0.
  always_comb begin
    div_n   = div_q;
    frame_n = frame_q;
    if (clear) begin
      div_n   = '0;
      frame_n = '0;
    end else if (enable) begin
      if (div_q == DIV_LAST) begin
        div_n   = '0;
        frame_n = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
      end else begin
        div_n = div_q + 1'b1;
      end
    end
  end

  // Divider and frame registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      frame_q <= '0;
    end else begin
      div_q   <= div_n;
      frame_q <= frame_n;
    end
  end

  assign frame = frame_q;

endmodule

// File: rtl/player_motion_ctrl.sv
// Player motion FSM: run / jump / crouch / dead, advanced once per game tick.
module player_motion_ctrl
  import player_pkg::*;
#(
  parameter int X_WIDTH    = 8,
  parameter int Y_WIDTH    = 9,
  parameter int VEL_WIDTH  = 8,   // must stay below X_WIDTH+2
  parameter int GROUND_X   = GROUND_X_DEF,
  parameter int PLAYER_Y   = PLAYER_Y_DEF,
  parameter int MAX_X      = MAX_X_DEF,
  parameter int JUMP_VEL   = 12,
  parameter int GRAVITY    = 2,
  parameter int RUN_FRAMES = 3,
  parameter int ANIM_DIV   = 1,
  parameter int JUMP_ID    = JUMP_ID_DEF,
  parameter int CROUCH_ID  = CROUCH_ID_DEF,
  parameter int DEAD_ID    = DEAD_ID_DEF
) (
  input logic                 clk,
  input logic                 reset,
  player_motion_ctrl_if.slave bus
);

  // Height arithmetic is signed with two guard bits so x+vel can neither
  // wrap past the ceiling nor go negative unnoticed on descent.
  localparam int SW = X_WIDTH + 2;

  localparam logic [X_WIDTH-1:0]         GX       = X_WIDTH'(GROUND_X);
  localparam logic [X_WIDTH-1:0]         MX       = X_WIDTH'(MAX_X);
  localparam logic signed [SW-1:0]       GROUND_S = SW'(GROUND_X);
  localparam logic signed [SW-1:0]       MAX_S    = SW'(MAX_X);
  localparam logic signed [VEL_WIDTH-1:0] JV      = VEL_WIDTH'(JUMP_VEL);
  localparam logic signed [VEL_WIDTH:0]  GRAV_S   = (VEL_WIDTH+1)'(GRAVITY);
  // Most negative VEL_WIDTH value, sign-extended by one bit.
  localparam logic signed [VEL_WIDTH:0]  VMIN_EXT = {2'b11, {(VEL_WIDTH-1){1'b0}}};

  state_t                      state_q, state_n;
  logic [X_WIDTH-1:0]          x_q, x_n;
  logic signed [VEL_WIDTH-1:0] vel_q, vel_n;
  logic signed [SW-1:0]        vel_ext, sum;
  logic signed [VEL_WIDTH:0]   vel_dec;
  logic                        anim_en, anim_clr;
  logic [ID_WIDTH-1:0]         frame;

  run_anim_counter #(
    .RUN_FRAMES (RUN_FRAMES),
    .ANIM_DIV   (ANIM_DIV)
  ) u_anim (
    .clk    (clk),
    .reset  (reset),
    .clear  (anim_clr),
    .enable (anim_en),
    .frame  (frame)
  );

  // Next state / position / velocity; collision pre-empts every live state.
  always_comb begin
    state_n  = state_q;
    x_n      = x_q;
    vel_n    = vel_q;
    anim_en  = 1'b0;
    anim_clr = 1'b0;
    vel_ext  = {{(SW-VEL_WIDTH){vel_q[VEL_WIDTH-1]}}, vel_q};
    sum      = $signed({2'b00, x_q}) + vel_ext;
    vel_dec  = {vel_q[VEL_WIDTH-1], vel_q} - GRAV_S;
    if (bus.update) begin
      if (state_q != ST_DEAD && bus.collision) begin
        state_n = ST_DEAD;
        vel_n   = '0;
      end else begin
        unique case (state_q)
          ST_RUN: begin
            x_n = GX;
            if (!bus.keys[0]) begin
              state_n = ST_JUMP;
              vel_n   = JV;
            end else if (!bus.keys[1]) begin
              state_n = ST_CROUCH;
            end else begin
              anim_en = 1'b1;
            end
          end
          ST_JUMP: begin
            if (vel_q < 0 && sum <= GROUND_S) begin
              // Land exactly on the floor rather than sinking below it.
              state_n  = ST_RUN;
              x_n      = GX;
              vel_n    = '0;
              anim_clr = 1'b1;
            end else if (sum > MAX_S) begin
              // Ceiling bump: stop dead, gravity takes over next tick.
              x_n   = MX;
              vel_n = '0;
            end else begin
              x_n   = sum[X_WIDTH-1:0];
              vel_n = (vel_dec < VMIN_EXT) ? VMIN_EXT[VEL_WIDTH-1:0]
                                           : vel_dec[VEL_WIDTH-1:0];
            end
          end
          ST_CROUCH: begin
            x_n = GX;
            if (bus.keys[1]) begin
              state_n  = ST_RUN;
              anim_clr = 1'b1;
            end
          end
          ST_DEAD: begin
            if (bus.restart) begin
              state_n  = ST_RUN;
              x_n      = GX;
              vel_n    = '0;
              anim_clr = 1'b1;
            end
          end
          default: state_n = ST_RUN;
        endcase
      end
    end
  end

  // State, height and velocity registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      x_q     <= GX;
      vel_q   <= '0;
    end else begin
      state_q <= state_n;
      x_q     <= x_n;
      vel_q   <= vel_n;
    end
  end

  // Sprite id decode; every source is a register, so outputs never see inputs.
  always_comb begin
    bus.spriteId = frame;
    unique case (state_q)
      ST_JUMP:   bus.spriteId = ID_WIDTH'(JUMP_ID);
      ST_CROUCH: bus.spriteId = ID_WIDTH'(CROUCH_ID);
      ST_DEAD:   bus.spriteId = ID_WIDTH'(DEAD_ID);
      default:   bus.spriteId = frame;
    endcase
  end

  assign bus.xSprite  = x_q;
  assign bus.ySprite  = Y_WIDTH'(PLAYER_Y);
  assign bus.airborne = (state_q == ST_JUMP);
  assign bus.dead     = (state_q == ST_DEAD);

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: a default instance and a high-jump instance
// share stimulus; each is compared against a per-tick behavioural model.
module tb_player_motion_ctrl;

  localparam int S_RUN = 0, S_JUMP = 1, S_CROUCH = 2, S_DEAD = 3;
  localparam int GROUND = 95, CEIL = 239, LANE = 119, GRAV = 2, NFR = 3, ADIV = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic upd = 1'b0, coll = 1'b0, rst_in = 1'b0;
  logic [3:0] kin = 4'hF;

  always #5 clk = ~clk;

  player_motion_ctrl_if #(.X_WIDTH(8), .Y_WIDTH(9)) ifa ();
  player_motion_ctrl_if #(.X_WIDTH(8), .Y_WIDTH(9)) ifb ();

  assign ifa.update = upd;  assign ifb.update = upd;
  assign ifa.keys = kin;    assign ifb.keys = kin;
  assign ifa.collision = coll; assign ifb.collision = coll;
  assign ifa.restart = rst_in; assign ifb.restart = rst_in;

  player_motion_ctrl u_dut0 (.clk(clk), .reset(reset), .bus(ifa));

  player_motion_ctrl #(.VEL_WIDTH(9), .JUMP_VEL(200)) u_dut1 (
    .clk(clk), .reset(reset), .bus(ifb));

  int n_chk = 0, n_fail = 0;

  // Model state, one slot per DUT.
  int m_st[2], m_x[2], m_vel[2], m_div[2], m_fr[2];
  int jv[2] = '{12, 200};
  int vw[2] = '{8, 9};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int obs_x(input int d);
    return (d == 0) ? int'(ifa.xSprite) : int'(ifb.xSprite);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_st[d] = S_RUN; m_x[d] = GROUND; m_vel[d] = 0; m_div[d] = 0; m_fr[d] = 0;
    end
  endtask

  task automatic enter_run(input int d);
    m_st[d] = S_RUN; m_x[d] = GROUND; m_vel[d] = 0; m_div[d] = 0; m_fr[d] = 0;
  endtask

  task automatic model_step(input int d, input logic [3:0] k, input bit c, input bit r);
    int s, vmin;
    vmin = -(1 << (vw[d] - 1));
    if (m_st[d] != S_DEAD && c) begin
      m_st[d] = S_DEAD; m_vel[d] = 0;
      return;
    end
    case (m_st[d])
      S_RUN: begin
        m_x[d] = GROUND;
        if (!k[0]) begin m_st[d] = S_JUMP; m_vel[d] = jv[d]; end
        else if (!k[1]) m_st[d] = S_CROUCH;
        else begin
          m_div[d]++;
          if (m_div[d] >= ADIV) begin m_div[d] = 0; m_fr[d] = (m_fr[d] + 1) % NFR; end
        end
      end
      S_JUMP: begin
        s = m_x[d] + m_vel[d];
        if (m_vel[d] < 0 && s <= GROUND) enter_run(d);
        else if (s > CEIL) begin m_x[d] = CEIL; m_vel[d] = 0; end
        else begin
          m_x[d] = s;
          m_vel[d] = (m_vel[d] - GRAV < vmin) ? vmin : m_vel[d] - GRAV;
        end
      end
      S_CROUCH: if (k[1]) enter_run(d);
      default:  if (r) enter_run(d);
    endcase
  endtask

  function automatic int exp_id(input int d);
    case (m_st[d])
      S_RUN:    return m_fr[d];
      S_JUMP:   return 3;
      S_CROUCH: return 4;
      default:  return 5;
    endcase
  endfunction

  task automatic check_all(input string ph);
    chk({ph, ".x0"},  ifa.xSprite,  m_x[0]);
    chk({ph, ".y0"},  ifa.ySprite,  LANE);
    chk({ph, ".id0"}, ifa.spriteId, exp_id(0));
    chk({ph, ".ab0"}, ifa.airborne, m_st[0] == S_JUMP);
    chk({ph, ".dd0"}, ifa.dead,     m_st[0] == S_DEAD);
    chk({ph, ".x1"},  ifb.xSprite,  m_x[1]);
    chk({ph, ".y1"},  ifb.ySprite,  LANE);
    chk({ph, ".id1"}, ifb.spriteId, exp_id(1));
    chk({ph, ".ab1"}, ifb.airborne, m_st[1] == S_JUMP);
    chk({ph, ".dd1"}, ifb.dead,     m_st[1] == S_DEAD);
  endtask

  // One clock: drive on the falling edge, sample 1ns after the rising edge.
  task automatic tick(input string ph, input bit u, input logic [3:0] k, input bit c, input bit r);
    @(negedge clk);
    upd = u; kin = k; coll = c; rst_in = r;
    @(posedge clk);
    #1;
    if (u) for (int d = 0; d < 2; d++) model_step(d, k, c, r);
    upd = 1'b0; coll = 1'b0; rst_in = 1'b0;
    check_all(ph);
  endtask

  int run_ids[7] = '{1, 2, 0, 1, 2, 0, 1};
  int jump_x[13] = '{107, 117, 125, 131, 135, 137, 137, 135, 131, 125, 117, 107, 95};

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) reset = 1'b0;

    // Idle running: animation cycles; idle clocks in between must hold.
    for (int i = 0; i < 7; i++) begin
      tick("run", 1'b1, 4'hF, 1'b0, 1'b0);
      chk("run_seq", ifa.spriteId, run_ids[i]);
      tick("hold", 1'b0, 4'b1100, 1'b1, 1'b1);
    end

    // Jump arc; the high-jump instance clamps at the ceiling.
    tick("jstart", 1'b1, 4'b1110, 1'b0, 1'b0);
    chk("jstart_id", ifa.spriteId, 3);
    for (int i = 0; i < 14; i++) begin
      tick("jump", 1'b1, 4'hF, 1'b0, 1'b0);
      if (i < 13) chk("jump_arc", ifa.xSprite, jump_x[i]);
      if (i == 0) chk("ceil_clamp", ifb.xSprite, CEIL);
      if (i == 1) chk("ceil_hold", ifb.xSprite, CEIL);
      if (i == 12) chk("land_ab", ifa.airborne, 0);
      if (i == 12) chk("land_id", ifa.spriteId, 0);
    end
    chk("land_hi", ifb.xSprite, GROUND);
    chk("land_hi_ab", ifb.airborne, 0);

    // Both keys: jump wins.
    tick("both", 1'b1, 4'b1100, 1'b0, 1'b0);
    chk("both_ab", ifa.airborne, 1);
    for (int i = 0; i < 14; i++) tick("both_arc", 1'b1, 4'hF, 1'b0, 1'b0);

    // Crouch held, then released.
    for (int i = 0; i < 6; i++) begin
      tick("crouch", 1'b1, 4'b1101, 1'b0, 1'b0);
      chk("crouch_id", ifa.spriteId, 4);
    end
    tick("uncrouch", 1'b1, 4'hF, 1'b0, 1'b0);
    chk("uncrouch_id", ifa.spriteId, 0);

    // Collision mid-jump, keys ignored while dead, then restart.
    tick("j2", 1'b1, 4'b1110, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick("j2", 1'b1, 4'hF, 1'b0, 1'b0);
    tick("hit", 1'b1, 4'hF, 1'b1, 1'b0);
    chk("hit_x", ifa.xSprite, 125);
    chk("hit_id", ifa.spriteId, 5);
    chk("hit_dead", ifa.dead, 1);
    for (int i = 0; i < 2; i++) tick("dead", 1'b1, 4'b1110, 1'b1, 1'b0);
    tick("restart", 1'b1, 4'hF, 1'b0, 1'b1);
    chk("restart_x", ifa.xSprite, GROUND);

    // Async reset mid-jump, between strobes.
    tick("j3", 1'b1, 4'b1110, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) tick("j3", 1'b1, 4'hF, 1'b0, 1'b0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_all("midreset");
    chk("midreset_x", ifa.xSprite, GROUND);
    @(negedge clk) reset = 1'b0;

    // Random play.
    for (int i = 0; i < 600; i++) begin
      tick("rand", ($urandom % 3) != 0, 4'($urandom), ($urandom % 12) == 0,
           ($urandom % 4) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // Backstop so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", n_chk, 0);
    $fatal(1, "timeout");
  end

endmodule
